// File: rtl/uart_rx_cfg.sv
// ============================================================================
// uart_rx_cfg
// ----------------------------------------------------------------------------
// Parametrised UART receiver for the sensor link. Oversamples the line,
// takes a 3-sample majority vote around mid-bit, checks optional parity and
// one or two stop bits, and hands each word to the consumer through a
// valid/ack holding register with per-word error flags.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD_RATE   line rate in bit/s
//   DATA_BITS   data bits per frame (5..9)
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   stop bits checked (1 or 2)
//   OVERSAMPLE  sample ticks per bit (even, >= 8)
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   rx_in        asynchronous serial line, idles high
//   data_out     received word, LSB = first data bit on the line
//   data_valid   holding register full, held until acknowledged
//   data_ack     consumer takes data_out when data_valid & data_ack
//   parity_err   parity mismatch for the held word
//   frame_err    a sampled stop bit was 0 for the held word
//   overrun_err  sticky: a frame completed while data_valid was 1
//   break_det    (UART_RX_BREAK_DET_EN only) one-cycle pulse on a break
//   busy         receiver is in any state other than IDLE
//
// Optional feature macro: UART_RX_BREAK_DET_EN
//   When defined, an all-zero frame (data, parity and stop bits) is reported
//   on break_det instead of being delivered, and the receiver waits for one
//   full bit time of idle line before looking for the next start bit.
// ============================================================================
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  // Clock divider producing OVERSAMPLE ticks per bit.
  localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SAMP_W-1:0] S_PRE     = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] S_MID     = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] S_VOTE    = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SAMP_W-1:0] S_LAST    = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(DATA_BITS);

  // Reject configurations the datapath cannot support.
  if (DIV < 1) begin : g_div_check
    $error("uart_rx_cfg: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE (DIV < 1)");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_check
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
    $error("uart_rx_cfg: OVERSAMPLE must be even and at least 8");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
`ifdef UART_RX_BREAK_DET_EN
    ST_STOP2,
    ST_BREAK
`else
    ST_STOP2
`endif
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_d;
  logic [1:0]           settle_cnt;
  logic                 settle_done;

  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [SAMP_W-1:0]    samp_cnt;
  logic                 vote_tick;
  logic                 end_tick;

  logic                 s_early;
  logic                 s_mid;
  logic                 vote;

  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 stop_bad;
  logic                 par_xor;
  logic                 par_err_new;

  logic                 start_det;
  logic                 frame_end;
  logic                 frame_ferr;
  logic                 frame_done;

`ifdef UART_RX_BREAK_DET_EN
  logic                 is_break;
  logic                 stops_zero;
  logic [SAMP_W-1:0]    brk_cnt;
`endif

  // Two-flop synchroniser plus one history flop for edge detection. The
  // settle counter keeps start detection off until the pipeline holds real
  // line samples, so a line that is low when reset is released cannot look
  // like a fresh falling edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      settle_cnt <= 2'd0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      if (settle_cnt != 2'd3) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
    end
  end

  assign settle_done = (settle_cnt == 2'd3);
  assign start_det   = (state == ST_IDLE) && settle_done && rx_d && !rx_s;

  assign tick      = (div_cnt == DIV_LAST);
  assign vote_tick = tick && (samp_cnt == S_VOTE);
  assign end_tick  = tick && (samp_cnt == S_LAST);
  assign vote      = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);

  // Tick generator and per-bit sample counter. Both free-run and are
  // realigned to the falling edge of each start bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (start_det) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Bits are judged on the vote tick; states advance on
  // the last tick of the bit, except that the frame finishes on the vote
  // tick of the final stop bit so the receiver is ready half a bit early.
  always_comb begin
    state_nxt  = state;
    frame_end  = 1'b0;
    frame_ferr = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    is_break   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start_det) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (vote_tick && vote) begin
          state_nxt = ST_IDLE;
        end else if (end_tick) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (end_tick && (bit_cnt == BITS_LAST)) begin
          state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP1;
        end
      end
      ST_PARITY: begin
        if (end_tick) begin
          state_nxt = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (STOP_BITS == 1) begin
          if (vote_tick) begin
            frame_end  = 1'b1;
            frame_ferr = !vote;
            state_nxt  = ST_IDLE;
          end
        end else if (end_tick) begin
          state_nxt = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (vote_tick) begin
          frame_end  = 1'b1;
          frame_ferr = stop_bad | !vote;
          state_nxt  = ST_IDLE;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      ST_BREAK: begin
        if (tick && rx_s && (brk_cnt == S_LAST)) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
`ifdef UART_RX_BREAK_DET_EN
    is_break = frame_end && (shift_reg == '0) &&
               ((PARITY == 0) || !par_bit) && stops_zero;
    if (is_break) begin
      state_nxt = ST_BREAK;
    end
`endif
  end

`ifdef UART_RX_BREAK_DET_EN
  // Only meaningful on the final stop-bit vote tick.
  assign stops_zero = ((STOP_BITS == 1) || stop_bad) && !vote;
  assign frame_done = frame_end && !is_break;
`else
  assign frame_done = frame_end;
`endif

  assign busy = (state != ST_IDLE);

  // Sample capture and frame assembly. Data shifts in from the top so the
  // first bit on the line ends up in bit 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_early   <= 1'b1;
      s_mid     <= 1'b1;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      stop_bad  <= 1'b0;
    end else begin
      if (tick && (samp_cnt == S_PRE)) begin
        s_early <= rx_s;
      end
      if (tick && (samp_cnt == S_MID)) begin
        s_mid <= rx_s;
      end
      if (start_det) begin
        bit_cnt  <= '0;
        par_bit  <= 1'b0;
        stop_bad <= 1'b0;
      end else if (vote_tick) begin
        case (state)
          ST_DATA: begin
            shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
          ST_PARITY: begin
            par_bit <= vote;
          end
          ST_STOP1: begin
            stop_bad <= !vote;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // The XOR over data plus received parity bit is 1 for a correct odd frame
  // and 0 for a correct even frame.
  assign par_xor     = (^shift_reg) ^ par_bit;
  assign par_err_new = (PARITY == 1) ? !par_xor :
                       (PARITY == 2) ?  par_xor : 1'b0;

  // Holding register. A completing frame loads when the register is empty
  // or is being acknowledged in the same cycle; otherwise it is dropped and
  // overrun is flagged. An ack on its own empties the register and clears
  // the flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (frame_done) begin
      if (!data_valid || data_ack) begin
        data_out   <= shift_reg;
        parity_err <= par_err_new;
        frame_err  <= frame_ferr;
        data_valid <= 1'b1;
        if (data_valid) begin
          overrun_err <= 1'b0;
        end
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (data_valid && data_ack) begin
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // Break pulse and idle-line counter used to leave the BREAK state; any low
  // sample restarts the full-bit wait.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      break_det <= 1'b0;
      brk_cnt   <= '0;
    end else begin
      break_det <= is_break;
      if ((state != ST_BREAK) || !rx_s) begin
        brk_cnt <= '0;
      end else if (tick) begin
        brk_cnt <= brk_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ============================================================================
// tb_uart_rx_cfg
// ----------------------------------------------------------------------------
// Directed bench for uart_rx_cfg. Two receivers run on a fast clock so a
// bit lasts 32 clocks (DIV = 2, OVERSAMPLE = 16):
//   dut_a : 8 data bits, no parity, 1 stop bit
//   dut_b : 8 data bits, even parity, 2 stop bits
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, so every check sees values registered on that edge.
// ============================================================================
module tb_uart_rx_cfg;

  localparam int OS     = 16;
  localparam int DIV_TB = 2;
  localparam int BAUD   = 9600;
  localparam int CLK_HZ = BAUD * OS * DIV_TB;
  localparam int BIT    = OS * DIV_TB;

  logic       clk;
  logic       reset_n;

  logic       rx_a;
  logic       ack_a;
  logic [7:0] data_a;
  logic       valid_a;
  logic       perr_a;
  logic       ferr_a;
  logic       oerr_a;
  logic       busy_a;

  logic       rx_b;
  logic       ack_b;
  logic [7:0] data_b;
  logic       valid_b;
  logic       perr_b;
  logic       ferr_b;
  logic       oerr_b;
  logic       busy_b;

`ifdef UART_RX_BREAK_DET_EN
  logic       brk_a;
  logic       brk_b;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  uart_rx_cfg #(
    .CLK_FREQ   (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .DATA_BITS  (8),
    .PARITY     (0),
    .STOP_BITS  (1),
    .OVERSAMPLE (OS)
  ) dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_in       (rx_a),
    .data_out    (data_a),
    .data_valid  (valid_a),
    .data_ack    (ack_a),
    .parity_err  (perr_a),
    .frame_err   (ferr_a),
    .overrun_err (oerr_a),
`ifdef UART_RX_BREAK_DET_EN
    .break_det   (brk_a),
`endif
    .busy        (busy_a)
  );

  uart_rx_cfg #(
    .CLK_FREQ   (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .DATA_BITS  (8),
    .PARITY     (2),
    .STOP_BITS  (2),
    .OVERSAMPLE (OS)
  ) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_in       (rx_b),
    .data_out    (data_b),
    .data_valid  (valid_b),
    .data_ack    (ack_b),
    .parity_err  (perr_b),
    .frame_err   (ferr_b),
    .overrun_err (oerr_b),
`ifdef UART_RX_BREAK_DET_EN
    .break_det   (brk_b),
`endif
    .busy        (busy_b)
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives nbits of 'bits' LSB-first, one bit time each, on line a (0) or b.
  task automatic applyStimulus(input int which, input logic [15:0] bits,
                               input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (which == 0) rx_a = bits[i];
      else            rx_b = bits[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic frameA(input logic [7:0] data);
    applyStimulus(0, {6'b0, 1'b1, data, 1'b0}, 10);
  endtask

  task automatic frameB(input logic [7:0] data, input logic par,
                        input logic stop1, input logic stop2);
    applyStimulus(1, {4'b0, stop2, stop1, par, data, 1'b0}, 12);
  endtask

  task automatic ackA();
    ack_a = 1'b1;
    idleCycles(1);
    ack_a = 1'b0;
  endtask

  task automatic ackB();
    ack_b = 1'b1;
    idleCycles(1);
    ack_b = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    ack_a   = 1'b0;
    ack_b   = 1'b0;
    idleCycles(5);

    // Reset state.
    checkOutput("rst_data_a",  32'(data_a),  32'h0);
    checkOutput("rst_valid_a", 32'(valid_a), 32'h0);
    checkOutput("rst_perr_a",  32'(perr_a),  32'h0);
    checkOutput("rst_ferr_a",  32'(ferr_a),  32'h0);
    checkOutput("rst_oerr_a",  32'(oerr_a),  32'h0);
    checkOutput("rst_busy_a",  32'(busy_a),  32'h0);
    checkOutput("rst_valid_b", 32'(valid_b), 32'h0);
    checkOutput("rst_busy_b",  32'(busy_b),  32'h0);
    reset_n = 1'b1;
    idleCycles(10);

    // 0xA5, 8N1. Mid-sample of the stop bit is registered 311 clocks after
    // the start bit is driven, so valid must be 0 at +310 and 1 at +311.
    applyStimulus(0, 16'h0000, 1);
    checkOutput("a5_busy_start", 32'(busy_a), 32'h1);
    applyStimulus(0, {8'h00, 8'hA5}, 8);
    rx_a = 1'b1;
    idleCycles(22);
    checkOutput("a5_valid_pre", 32'(valid_a), 32'h0);
    checkOutput("a5_busy_pre",  32'(busy_a),  32'h1);
    idleCycles(1);
    checkOutput("a5_valid",     32'(valid_a), 32'h1);
    checkOutput("a5_busy_done", 32'(busy_a),  32'h0);
    checkOutput("a5_data",      32'(data_a),  32'hA5);
    checkOutput("a5_perr",      32'(perr_a),  32'h0);
    checkOutput("a5_ferr",      32'(ferr_a),  32'h0);
    checkOutput("a5_oerr",      32'(oerr_a),  32'h0);
    idleCycles(3);
    checkOutput("a5_valid_hold", 32'(valid_a), 32'h1);
    ackA();
    checkOutput("a5_valid_ack", 32'(valid_a), 32'h0);
    idleCycles(15);

    // Low glitch of 4 ticks: a start is seen, then rejected by the vote.
    rx_a = 1'b0;
    idleCycles(4 * DIV_TB);
    rx_a = 1'b1;
    checkOutput("glitch_busy",      32'(busy_a),  32'h1);
    idleCycles(BIT);
    checkOutput("glitch_busy_end",  32'(busy_a),  32'h0);
    checkOutput("glitch_valid",     32'(valid_a), 32'h0);

    // Two frames without ack: the second is dropped and overrun is flagged.
    frameA(8'h11);
    idleCycles(5);
    frameA(8'h22);
    checkOutput("ovr_valid", 32'(valid_a), 32'h1);
    checkOutput("ovr_data",  32'(data_a),  32'h11);
    checkOutput("ovr_oerr",  32'(oerr_a),  32'h1);
    ackA();
    checkOutput("ovr_ack_valid", 32'(valid_a), 32'h0);
    checkOutput("ovr_ack_oerr",  32'(oerr_a),  32'h0);
    checkOutput("ovr_ack_perr",  32'(perr_a),  32'h0);
    checkOutput("ovr_ack_ferr",  32'(ferr_a),  32'h0);
    idleCycles(10);

    // Ack on exactly the completion cycle of the second frame.
    frameA(8'h11);
    idleCycles(5);
    applyStimulus(0, 16'h0000, 1);
    applyStimulus(0, {8'h00, 8'h22}, 8);
    rx_a = 1'b1;
    idleCycles(22);
    checkOutput("coin_pre_data",  32'(data_a), 32'h11);
    checkOutput("coin_pre_oerr",  32'(oerr_a), 32'h0);
    ack_a = 1'b1;
    idleCycles(1);
    ack_a = 1'b0;
    checkOutput("coin_valid", 32'(valid_a), 32'h1);
    checkOutput("coin_data",  32'(data_a),  32'h22);
    checkOutput("coin_oerr",  32'(oerr_a),  32'h0);
    idleCycles(19);
    ackA();
    checkOutput("coin_final_valid", 32'(valid_a), 32'h0);

    // Even parity, 2 stop bits. 0x3C has four ones, so parity bit 1 is wrong.
    frameB(8'h3C, 1'b1, 1'b1, 1'b1);
    checkOutput("par_bad_valid", 32'(valid_b), 32'h1);
    checkOutput("par_bad_data",  32'(data_b),  32'h3C);
    checkOutput("par_bad_perr",  32'(perr_b),  32'h1);
    checkOutput("par_bad_ferr",  32'(ferr_b),  32'h0);
    ackB();
    idleCycles(10);
    frameB(8'h3C, 1'b0, 1'b1, 1'b1);
    checkOutput("par_ok_data", 32'(data_b), 32'h3C);
    checkOutput("par_ok_perr", 32'(perr_b), 32'h0);
    ackB();
    idleCycles(10);

    // 0x81 with a bad second stop bit, then a clean 0x55.
    frameB(8'h81, 1'b0, 1'b1, 1'b0);
    rx_b = 1'b1;
    checkOutput("stop2_data", 32'(data_b), 32'h81);
    checkOutput("stop2_ferr", 32'(ferr_b), 32'h1);
    checkOutput("stop2_perr", 32'(perr_b), 32'h0);
    ackB();
    checkOutput("stop2_ack_ferr",  32'(ferr_b),  32'h0);
    checkOutput("stop2_ack_valid", 32'(valid_b), 32'h0);
    idleCycles(40);
    frameB(8'h55, 1'b0, 1'b1, 1'b1);
    checkOutput("next_valid", 32'(valid_b), 32'h1);
    checkOutput("next_data",  32'(data_b),  32'h55);
    checkOutput("next_perr",  32'(perr_b),  32'h0);
    checkOutput("next_ferr",  32'(ferr_b),  32'h0);
    ackB();
    idleCycles(10);

    // Reset in the middle of data bit 3 of 0xF0 (start + bits 0..2 are 0).
    applyStimulus(0, 16'h0000, 4);
    rx_a = 1'b0;
    idleCycles(16);
    checkOutput("mid_busy",     32'(busy_a), 32'h1);
    checkOutput("mid_data_old", 32'(data_a), 32'h22);
    reset_n = 1'b0;
    idleCycles(4);
    checkOutput("mid_rst_data_a",  32'(data_a),  32'h0);
    checkOutput("mid_rst_valid_a", 32'(valid_a), 32'h0);
    checkOutput("mid_rst_busy_a",  32'(busy_a),  32'h0);
    checkOutput("mid_rst_oerr_a",  32'(oerr_a),  32'h0);
    checkOutput("mid_rst_data_b",  32'(data_b),  32'h0);
    reset_n = 1'b1;
    idleCycles(12);
    checkOutput("no_retrigger", 32'(busy_a), 32'h0);
    rx_a = 1'b1;
    idleCycles(20);
    frameA(8'h0F);
    checkOutput("post_rst_valid", 32'(valid_a), 32'h1);
    checkOutput("post_rst_data",  32'(data_a),  32'h0F);
    checkOutput("post_rst_perr",  32'(perr_a),  32'h0);
    checkOutput("post_rst_ferr",  32'(ferr_a),  32'h0);
    checkOutput("post_rst_oerr",  32'(oerr_a),  32'h0);
    ackA();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
